// File: rtl/load_store_unit.sv
// load_store_unit: request-driven load/store FSM in front of a single-port data memory with alignment checking.
// Define LSU_SUBWORD_EN to enable byte/halfword accesses (read-modify-write stores, extended loads).
module load_store_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-3:0] mem_Address,
    output logic [DATA_WIDTH-1:0] mem_WriteData,
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    input  logic [DATA_WIDTH-1:0] mem_ReadData
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateT;
    stateT state;
    logic bad, rmw;
    logic [DATA_WIDTH-1:0] loadData, merged;
`ifdef LSU_SUBWORD_EN
    logic writeQ, unsignedQ;
    logic [1:0] sizeQ, offQ;
    logic [DATA_WIDTH-1:0] wdataQ, mask;
    logic [4:0] shamt;
    logic [7:0] byteLane;
    logic [15:0] halfLane;
    always_ff @(posedge clk)
        if (state == IDLE && req_valid) begin
            writeQ <= req_write;
            unsignedQ <= req_unsigned;
            sizeQ <= req_size;
            offQ <= req_addr[1:0];
            wdataQ <= req_wdata;
        end
    always_comb begin
        bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        shamt = {offQ, 3'b000};
        byteLane = mem_ReadData[shamt +: 8];
        halfLane = offQ[1] ? mem_ReadData[31:16] : mem_ReadData[15:0];
        loadData = sizeQ == 2'b00 ? {{(DATA_WIDTH-8){~unsignedQ & byteLane[7]}}, byteLane} :
                   sizeQ == 2'b01 ? {{(DATA_WIDTH-16){~unsignedQ & halfLane[15]}}, halfLane} : mem_ReadData;
        mask = (sizeQ == 2'b00 ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << shamt;
        merged = (mem_ReadData & ~mask) | ((wdataQ << shamt) & mask);
        rmw = writeQ;
    end
`else
    logic unusedUnsigned;
    assign unusedUnsigned = req_unsigned;
    always_comb begin
        bad = req_size != 2'b10 || req_addr[1:0] != 2'b00;
        loadData = mem_ReadData;
        merged = '0;
        rmw = 1'b0;
    end
`endif
    assign req_ready = state == IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            mem_Address <= '0;
            mem_WriteData <= '0;
            mem_MemWrite <= 1'b0;
            mem_MemRead <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    if (bad) begin
                        state <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                    end else if (!req_write || req_size != 2'b10) begin
                        state <= READ;
                        mem_MemRead <= 1'b1;
                        mem_Address <= req_addr[ADDR_WIDTH-1:2];
                    end else begin
                        state <= WRITE;
                        mem_MemWrite <= 1'b1;
                        mem_WriteData <= req_wdata;
                        mem_Address <= req_addr[ADDR_WIDTH-1:2];
                    end
                end
                READ: begin
                    mem_MemRead <= 1'b0;
                    if (rmw) begin
                        state <= WRITE;
                        mem_MemWrite <= 1'b1;
                        mem_WriteData <= merged;
                    end else begin
                        state <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= loadData;
                        mem_Address <= '0;
                    end
                end
                WRITE: begin
                    state <= RESP;
                    mem_MemWrite <= 1'b0;
                    mem_WriteData <= '0;
                    mem_Address <= '0;
                    rsp_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12: byte-address width; memory word address is ADDR_WIDTH-2 bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width (fixed 32 in this revision).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: core request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 The block SHALL have port req_unsigned, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-010 The block SHALL have port req_addr, input, ADDR_WIDTH bits: byte address.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_error, output, 1 bit: misaligned or illegal request; qualified by rsp_valid.
REQ-015 The block SHALL have port mem_Address, output, ADDR_WIDTH-2 bits: word address to data memory.
REQ-016 The block SHALL have port mem_WriteData, output, 32 bits: write word to data memory.
REQ-017 The block SHALL have port mem_MemWrite, output, 1 bit: memory writes on the clk edge ending the cycle.
REQ-018 The block SHALL have port mem_MemRead, output, 1 bit: enables the memory's combinational read data.
REQ-019 The block SHALL have port mem_ReadData, input, 32 bits: combinational read data, valid in the same cycle as mem_MemRead.

Function
REQ-020 The FSM SHALL use states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on an edge where req_valid && req_ready, capturing all req_* fields into registers.
REQ-022 A request SHALL be misaligned when a halfword has addr[0]!=0, or a word has addr[1:0]!=0.
REQ-023 A misaligned or size=11 request SHALL go IDLE->RESP with rsp_error=1 and no memory access.
REQ-024 A load SHALL go IDLE->READ->RESP; in READ, mem_MemRead=1 and mem_ReadData is captured; rsp_valid asserts 2 cycles after acceptance.
REQ-025 A word store SHALL go IDLE->WRITE->RESP; in WRITE, mem_MemWrite=1 and mem_WriteData=req_wdata.
REQ-026 A byte or halfword store SHALL go IDLE->READ->WRITE->RESP (read-modify-write), replacing only the addressed lanes; rsp_valid asserts 3 cycles after acceptance.
REQ-027 Byte lanes SHALL be little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24; halfword offset 2 = bits 31:16.
REQ-028 Loads SHALL select the addressed lane and sign- or zero-extend it to 32 bits per req_unsigned.
REQ-029 RESP SHALL last exactly one cycle with no backpressure, then return to IDLE.
REQ-030 A request presented during RESP SHALL be accepted no earlier than the following IDLE cycle.
REQ-031 mem_MemRead and mem_MemWrite SHALL never both be 1, and SHALL be 0 in IDLE and RESP.
REQ-032 mem_Address SHALL equal captured addr[ADDR_WIDTH-1:2] in READ and WRITE, and 0 otherwise.

Reset
REQ-033 While reset=1 at an edge, state SHALL become IDLE, and rsp_valid, rsp_error, rsp_rdata and all mem_* outputs SHALL become 0.
REQ-034 Reset SHALL override any pending request, and no response SHALL be issued for the aborted request.
REQ-035 If the WRITE cycle coincides with reset assertion, the memory write SHALL still occur on that edge.

Configuration
REQ-036 When macro LSU_SUBWORD_EN is defined, byte and halfword accesses SHALL behave as specified above.
REQ-037 When LSU_SUBWORD_EN is undefined, req_size 00 and 01 SHALL be treated as illegal (rsp_error=1), and read-modify-write logic and extension logic SHALL be omitted.

Verification
REQ-038 Word store of 0xDEADBEEF to addr 0x010, then word load from 0x010 -> mem_MemWrite pulses once with mem_Address=0x004; the load has rsp_rdata=0xDEADBEEF and rsp_error=0 two cycles after acceptance.
REQ-039 With mem word 0x11223344, byte store of 0xAA to addr 0x011 -> READ then WRITE with mem_WriteData=0x1122AA44; rsp_valid 3 cycles after acceptance.
REQ-040 With mem word 0x8000F0FF at 0x020: signed byte load at 0x020 -> 0xFFFFFFFF; unsigned halfword load at 0x020 -> 0x0000F0FF; signed halfword load at 0x022 -> 0xFFFF8000.
REQ-041 Word load at 0x013 and size=11 request -> each gives rsp_valid=1 and rsp_error=1 one cycle after acceptance, with no mem_MemRead and no mem_MemWrite.
REQ-042 Reset asserted during READ of a sub-word store -> next cycle in IDLE, no mem_MemWrite, no rsp_valid; a back-to-back request held across RESP is accepted in the following IDLE cycle.
REQ-043 Without LSU_SUBWORD_EN, byte load at 0x000 -> rsp_error=1 with no memory access.
